// File: rtl/thor2021_soc_shell.sv
// thor2021_soc_shell: board-level shell for the Thor2021 FPGA target.
// Runs the DDR3 power-up/initialisation sequence on the memory pins,
// parks the HDMI/TMDS outputs in a fixed idle pattern, and shows init
// status, a heartbeat and switch state on the LEDs. Single clock (xclk).
// Ports:
//   xclk, cpu_resetn         clock and asynchronous active-low board reset
//   sw[7:0]                  board switches
//   led[7:0]                 {sw[7:2] delayed, heartbeat MSB, init done}
//   TMDS_OUT_*               HDMI clock/data pairs (idle pattern)
//   ddr3_ck_p/n              forwarded xclk
//   ddr3_cke/reset_n         DDR3 power-up control
//   ddr3_ras_n/cas_n/we_n    command pins, ddr3_ba/ddr3_addr with them
//   ddr3_dq, ddr3_dqs_p/n    never driven (high-Z)
//   ddr3_dm, ddr3_odt        tied low
module thor2021_soc_shell #(
  parameter int unsigned RST_CYCLES = 20,
  parameter int unsigned CKE_DELAY  = 50,
  parameter int unsigned TXPR       = 8,
  parameter int unsigned TMRD       = 4,
  parameter int unsigned TMOD       = 12,
  parameter int unsigned TZQINIT    = 64,
  parameter logic [14:0] MR0        = 15'h0520,
  parameter logic [14:0] MR1        = 15'h0044,
  parameter logic [14:0] MR2        = 15'h0008,
  parameter logic [14:0] MR3        = 15'h0000,
  parameter int unsigned HB_BITS    = 24
) (
  input  logic        xclk,
  input  logic        cpu_resetn,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  output logic        TMDS_OUT_clk_p,
  output logic        TMDS_OUT_clk_n,
  output logic [2:0]  TMDS_OUT_data_p,
  output logic [2:0]  TMDS_OUT_data_n,
  output logic        ddr3_ck_p,
  output logic        ddr3_ck_n,
  output logic        ddr3_cke,
  output logic        ddr3_reset_n,
  output logic        ddr3_ras_n,
  output logic        ddr3_cas_n,
  output logic        ddr3_we_n,
  output logic [2:0]  ddr3_ba,
  output logic [14:0] ddr3_addr,
  inout  wire  [15:0] ddr3_dq,
  inout  wire  [1:0]  ddr3_dqs_p,
  inout  wire  [1:0]  ddr3_dqs_n,
  output logic [1:0]  ddr3_dm,
  output logic        ddr3_odt
);

  localparam int unsigned CNT_W = 16;

  localparam logic [2:0]  CMD_NOP  = 3'b111;
  localparam logic [2:0]  CMD_MRS  = 3'b000;
  localparam logic [2:0]  CMD_ZQCL = 3'b110;
  localparam logic [14:0] ZQ_ADDR  = 15'h0400;

  typedef enum logic [3:0] {
    S_RST_HOLD, S_CKE_WAIT, S_XPR,
    S_MRS2, S_MRS2_W, S_MRS3, S_MRS3_W,
    S_MRS1, S_MRS1_W, S_MRS0, S_MRS0_W,
    S_ZQCL, S_ZQ_W, S_DONE
  } state_e;

  // Reset release synchroniser; assertion stays asynchronous.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge xclk or negedge cpu_resetn) begin
    if (!cpu_resetn) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // Init sequencer: one elapsed-cycle counter shared by all timed states.
  // Command pins are loaded on the edge that enters a command state, so
  // each command occupies exactly the one cycle spent in that state.
  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               reset_n_q, cke_q, done_q;
  logic [2:0]         cmd_q, ba_q;
  logic [14:0]        addr_q;

  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RST_HOLD;
      cnt_q     <= '0;
      reset_n_q <= 1'b0;
      cke_q     <= 1'b0;
      done_q    <= 1'b0;
      cmd_q     <= CMD_NOP;
      ba_q      <= 3'd0;
      addr_q    <= 15'd0;
    end else begin
      cmd_q  <= CMD_NOP;
      ba_q   <= 3'd0;
      addr_q <= 15'd0;
      cnt_q  <= cnt_d;
      case (state_q)
        S_RST_HOLD: if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_q <= S_CKE_WAIT; cnt_q <= '0; reset_n_q <= 1'b1;
        end
        S_CKE_WAIT: if (cnt_q == CNT_W'(CKE_DELAY - 1)) begin
          state_q <= S_XPR; cnt_q <= '0; cke_q <= 1'b1;
        end
        S_XPR: if (cnt_q == CNT_W'(TXPR - 1)) begin
          state_q <= S_MRS2; cnt_q <= '0;
          cmd_q <= CMD_MRS; ba_q <= 3'd2; addr_q <= MR2;
        end
        S_MRS2: begin state_q <= S_MRS2_W; cnt_q <= '0; end
        S_MRS2_W: if (cnt_q == CNT_W'(TMRD - 1)) begin
          state_q <= S_MRS3; cnt_q <= '0;
          cmd_q <= CMD_MRS; ba_q <= 3'd3; addr_q <= MR3;
        end
        S_MRS3: begin state_q <= S_MRS3_W; cnt_q <= '0; end
        S_MRS3_W: if (cnt_q == CNT_W'(TMRD - 1)) begin
          state_q <= S_MRS1; cnt_q <= '0;
          cmd_q <= CMD_MRS; ba_q <= 3'd1; addr_q <= MR1;
        end
        S_MRS1: begin state_q <= S_MRS1_W; cnt_q <= '0; end
        S_MRS1_W: if (cnt_q == CNT_W'(TMRD - 1)) begin
          state_q <= S_MRS0; cnt_q <= '0;
          cmd_q <= CMD_MRS; ba_q <= 3'd0; addr_q <= MR0;
        end
        S_MRS0: begin state_q <= S_MRS0_W; cnt_q <= '0; end
        S_MRS0_W: if (cnt_q == CNT_W'(TMOD - 1)) begin
          state_q <= S_ZQCL; cnt_q <= '0;
          cmd_q <= CMD_ZQCL; addr_q <= ZQ_ADDR;
        end
        S_ZQCL: begin state_q <= S_ZQ_W; cnt_q <= '0; end
        S_ZQ_W: if (cnt_q == CNT_W'(TZQINIT - 1)) begin
          state_q <= S_DONE; cnt_q <= '0; done_q <= 1'b1;
        end
        S_DONE: cnt_q <= cnt_q;
        default: begin state_q <= S_RST_HOLD; cnt_q <= '0; end
      endcase
    end
  end

  assign ddr3_reset_n = reset_n_q;
  assign ddr3_cke     = cke_q;
  assign ddr3_ras_n   = cmd_q[2];
  assign ddr3_cas_n   = cmd_q[1];
  assign ddr3_we_n    = cmd_q[0];
  assign ddr3_ba      = ba_q;
  assign ddr3_addr    = addr_q;

  // Heartbeat, TMDS clock toggle and switch capture.
  logic [HB_BITS-1:0] hb_q, hb_d;
  logic               tmds_clk_q, tmds_clk_d;
  logic [5:0]         sw_q;

  assign hb_d       = hb_q + HB_BITS'(1);
  assign tmds_clk_d = ~tmds_clk_q;

  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      hb_q       <= '0;
      tmds_clk_q <= 1'b0;
      sw_q       <= 6'd0;
    end else begin
      hb_q       <= hb_d;
      tmds_clk_q <= tmds_clk_d;
      sw_q       <= sw[7:2];
    end
  end

  assign led = {sw_q, hb_q[HB_BITS-1], done_q};

  // sw[1:0] have no LED.
  logic unused_sw;
  assign unused_sw = ^sw[1:0];

  assign TMDS_OUT_clk_p  = tmds_clk_q;
  assign TMDS_OUT_clk_n  = ~tmds_clk_q;
  assign TMDS_OUT_data_p = 3'b000;
  assign TMDS_OUT_data_n = 3'b111;

  // Memory clock is xclk forwarded straight to the pins.
  assign ddr3_ck_p = xclk;
  assign ddr3_ck_n = ~xclk;

  assign ddr3_dq    = {16{1'bz}};
  assign ddr3_dqs_p = {2{1'bz}};
  assign ddr3_dqs_n = {2{1'bz}};
  assign ddr3_dm    = 2'b00;
  assign ddr3_odt   = 1'b0;

endmodule

// File: tb/tb_thor2021_soc_shell.sv
// Bench for thor2021_soc_shell: expected event times come from the timing
// parameters by plain arithmetic, counted in xclk edges after reset release.
module tb_thor2021_soc_shell;

  localparam int unsigned RST_CYCLES = 20;
  localparam int unsigned CKE_DELAY  = 50;
  localparam int unsigned TXPR       = 8;
  localparam int unsigned TMRD       = 4;
  localparam int unsigned TMOD       = 12;
  localparam int unsigned TZQINIT    = 64;
  localparam int unsigned HB_BITS    = 4;

  logic        xclk = 1'b0;
  logic        cpu_resetn;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic        tmds_clk_p, tmds_clk_n;
  logic [2:0]  tmds_data_p, tmds_data_n;
  logic        ck_p, ck_n, cke, ddr_rst_n, ras_n, cas_n, we_n, odt;
  logic [2:0]  ba;
  logic [14:0] addr;
  logic [1:0]  dm;
  wire  [15:0] dq;
  wire  [1:0]  dqs_p, dqs_n;

  logic        drv_en = 1'b0;
  logic [15:0] dq_drv = 16'h0;
  logic [1:0]  dqs_drv = 2'b0;
  assign dq    = drv_en ? dq_drv : {16{1'bz}};
  assign dqs_p = drv_en ? dqs_drv : {2{1'bz}};
  assign dqs_n = drv_en ? ~dqs_drv : {2{1'bz}};

  thor2021_soc_shell #(.HB_BITS(HB_BITS)) dut (
    .xclk(xclk), .cpu_resetn(cpu_resetn), .sw(sw), .led(led),
    .TMDS_OUT_clk_p(tmds_clk_p), .TMDS_OUT_clk_n(tmds_clk_n),
    .TMDS_OUT_data_p(tmds_data_p), .TMDS_OUT_data_n(tmds_data_n),
    .ddr3_ck_p(ck_p), .ddr3_ck_n(ck_n), .ddr3_cke(cke), .ddr3_reset_n(ddr_rst_n),
    .ddr3_ras_n(ras_n), .ddr3_cas_n(cas_n), .ddr3_we_n(we_n),
    .ddr3_ba(ba), .ddr3_addr(addr), .ddr3_dq(dq), .ddr3_dqs_p(dqs_p),
    .ddr3_dqs_n(dqs_n), .ddr3_dm(dm), .ddr3_odt(odt)
  );

  always #5 xclk = ~xclk;

  // Edges seen with cpu_resetn high; 0 while the board reset is held.
  int unsigned k = 0;
  always @(posedge xclk) k <= cpu_resetn ? k + 1 : 0;

  int checks = 0;
  int errors = 0;

  // Reference timeline.
  int unsigned k_rst_n, k_cke, k_done;
  int unsigned exp_k [5];
  logic [2:0]  exp_cmd [5];
  logic [2:0]  exp_ba [5];
  logic [14:0] exp_addr [5];
  int unsigned exp_gap [4];

  typedef struct {
    int unsigned k;
    logic [2:0]  cmd;
    logic [2:0]  ba;
    logic [14:0] addr;
  } cmd_t;
  cmd_t seen[$];

  task automatic build_model();
    logic [14:0] mr [4];
    int unsigned order [4];
    mr[0] = 15'h0520; mr[1] = 15'h0044; mr[2] = 15'h0008; mr[3] = 15'h0000;
    order[0] = 2; order[1] = 3; order[2] = 1; order[3] = 0;
    exp_gap[0] = TMRD; exp_gap[1] = TMRD; exp_gap[2] = TMRD; exp_gap[3] = TMOD;
    k_rst_n = 2 + RST_CYCLES;
    k_cke   = k_rst_n + CKE_DELAY;
    exp_k[0] = k_cke + TXPR;
    for (int i = 0; i < 4; i++) begin
      exp_cmd[i]  = 3'b000;
      exp_ba[i]   = 3'(order[i]);
      exp_addr[i] = mr[order[i]];
      exp_k[i+1]  = exp_k[i] + exp_gap[i] + 1;
    end
    exp_cmd[4] = 3'b110; exp_ba[4] = 3'd0; exp_addr[4] = 15'h0400;
    k_done = exp_k[4] + TZQINIT + 1;
  endtask

  task automatic step();
    @(negedge xclk);
  endtask

  task automatic test_reset();
    int unsigned hold;
    cpu_resetn = 1'b0;
    sw = 8'($urandom);
    hold = 5 + $urandom_range(0, 3);
    for (int i = 0; i < int'(hold); i++) step();
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led got=%h exp=00", led); end
    checks++; if ({ddr_rst_n, cke} !== 2'b00) begin errors++; $display("FAIL reset_rstn_cke got=%b exp=00", {ddr_rst_n, cke}); end
    checks++; if ({ras_n, cas_n, we_n, ba, addr} !== {3'b111, 3'd0, 15'd0}) begin
      errors++; $display("FAIL reset_cmd got=%b/%h/%h exp=111/0/0", {ras_n, cas_n, we_n}, ba, addr); end
    checks++; if (tmds_clk_p !== 1'b0) begin errors++; $display("FAIL reset_tmds got=%b exp=0", tmds_clk_p); end
    cpu_resetn = 1'b1;
    while (ddr_rst_n !== 1'b1 && k < k_rst_n + 20) begin
      step();
      if (k == 2) begin
        checks++; if (led !== 8'h00) begin errors++; $display("FAIL sync_led got=%h exp=00", led); end
      end
    end
    checks++; if (k != k_rst_n) begin errors++; $display("FAIL rstn_rise edge got=%0d exp=%0d", k, k_rst_n); end
  endtask

  task automatic test_init();
    int unsigned cke_k = 0, done_k = 0, idle_bad = 0, n;
    seen.delete();
    while (k < k_done + 2) begin
      step();
      if (cke === 1'b1 && cke_k == 0) cke_k = k;
      if (led[0] === 1'b1 && done_k == 0) done_k = k;
      if ({ras_n, cas_n, we_n} !== 3'b111) seen.push_back('{k, {ras_n, cas_n, we_n}, ba, addr});
      else if (ba !== 3'd0 || addr !== 15'd0) idle_bad++;
    end
    checks++; if (cke_k != k_cke) begin errors++; $display("FAIL cke_rise edge got=%0d exp=%0d", cke_k, k_cke); end
    checks++; if (seen.size() != 5) begin errors++; $display("FAIL cmd_count got=%0d exp=5", seen.size()); end
    n = (seen.size() < 5) ? seen.size() : 5;
    for (int i = 0; i < int'(n); i++) begin
      checks++;
      if (seen[i].cmd !== exp_cmd[i] || seen[i].ba !== exp_ba[i] || seen[i].addr !== exp_addr[i]) begin
        errors++; $display("FAIL cmd%0d got=%b/%0d/%h exp=%b/%0d/%h", i, seen[i].cmd, seen[i].ba,
                           seen[i].addr, exp_cmd[i], exp_ba[i], exp_addr[i]);
      end
      checks++; if (seen[i].k != exp_k[i]) begin errors++; $display("FAIL cmd%0d_time got=%0d exp=%0d", i, seen[i].k, exp_k[i]); end
      if (i > 0) begin
        checks++;
        if (seen[i].k - seen[i-1].k - 1 != exp_gap[i-1]) begin
          errors++; $display("FAIL gap%0d got=%0d exp=%0d", i - 1, seen[i].k - seen[i-1].k - 1, exp_gap[i-1]);
        end
      end
    end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL nop_ba_addr bad_cycles got=%0d exp=0", idle_bad); end
    checks++; if (done_k != k_done) begin errors++; $display("FAIL done_time got=%0d exp=%0d", done_k, k_done); end
  endtask

  task automatic test_done_hold();
    int unsigned bad = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if ({ras_n, cas_n, we_n, cke, ddr_rst_n, led[0]} !== 6'b111111 || ba !== 3'd0 || addr !== 15'd0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL done_hold bad_cycles got=%0d exp=0", bad); end
  endtask

  task automatic test_leds();
    logic [7:0] v;
    for (int i = 0; i < 14; i++) begin
      v = (i == 0) ? 8'hA5 : 8'($urandom);
      sw = v;
      step();
      checks++; if (led[7:2] !== v[7:2]) begin errors++; $display("FAIL led_sw got=%b exp=%b", led[7:2], v[7:2]); end
    end
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (led[1] !== 1'(((k - 2) >> (HB_BITS - 1)) & 1)) begin
        errors++; $display("FAIL heartbeat edge=%0d got=%b exp=%b", k, led[1], 1'(((k - 2) >> (HB_BITS - 1)) & 1));
      end
      checks++;
      if (tmds_clk_p !== 1'((k - 2) & 1)) begin
        errors++; $display("FAIL tmds_clk edge=%0d got=%b exp=%b", k, tmds_clk_p, 1'((k - 2) & 1));
      end
    end
  endtask

  task automatic test_static();
    logic [15:0] pat [3];
    pat[0] = 16'h0000; pat[1] = 16'hFFFF; pat[2] = 16'($urandom);
    step();
    checks++; if ({ck_p, ck_n} !== 2'b01) begin errors++; $display("FAIL ck_low got=%b exp=01", {ck_p, ck_n}); end
    checks++; if (dm !== 2'b00 || odt !== 1'b0) begin errors++; $display("FAIL dm_odt got=%b/%b exp=00/0", dm, odt); end
    checks++;
    if (tmds_data_p !== 3'b000 || tmds_data_n !== ~tmds_data_p || tmds_clk_n !== ~tmds_clk_p) begin
      errors++; $display("FAIL tmds_pairs got=%b/%b/%b/%b", tmds_data_p, tmds_data_n, tmds_clk_p, tmds_clk_n);
    end
    @(posedge xclk); #1;
    checks++; if ({ck_p, ck_n} !== 2'b10) begin errors++; $display("FAIL ck_high got=%b exp=10", {ck_p, ck_n}); end
    // DUT must leave the data bus free: whatever the bench drives reads back.
    for (int i = 0; i < 3; i++) begin
      drv_en = 1'b1; dq_drv = pat[i]; dqs_drv = pat[i][1:0];
      #1;
      checks++; if (dq !== pat[i]) begin errors++; $display("FAIL dq_free got=%h exp=%h", dq, pat[i]); end
      checks++;
      if (dqs_p !== pat[i][1:0] || dqs_n !== ~pat[i][1:0]) begin
        errors++; $display("FAIL dqs_free got=%b/%b exp=%b", dqs_p, dqs_n, pat[i][1:0]);
      end
    end
    drv_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int unsigned target;
    test_reset();
    target = exp_k[2] + 1 + $urandom_range(0, TMRD - 1);
    while (k < target) step();
    cpu_resetn = 1'b0;
    #1;
    checks++; if ({ras_n, cas_n, we_n} !== 3'b111) begin errors++; $display("FAIL mid_nop got=%b exp=111", {ras_n, cas_n, we_n}); end
    checks++; if ({cke, ddr_rst_n} !== 2'b00) begin errors++; $display("FAIL mid_cke_rstn got=%b exp=00", {cke, ddr_rst_n}); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL mid_led got=%h exp=00", led); end
    test_reset();
    test_init();
  endtask

  initial begin
    cpu_resetn = 1'b0;
    sw = 8'h00;
    build_model();
    step();
    test_reset();
    test_init();
    test_done_hold();
    test_leds();
    test_static();
    test_reset_mid();
    test_leds();
    test_static();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
